// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural integer register file with rename tags. Holds the 32 committed
// register values, tracks which registers have an in-flight producer (busy) and
// the ROB entry of that producer (tag), and resolves decoder source operands to
// either a ready value (committed, commit-bypassed or ROB-forwarded) or a ROB
// tag to wait on.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global stall when low)
//   issue_*        : rename of a destination register at issue
//   rob_commit, commit_* : retirement of a register result from the ROB head
//   clear_up       : misprediction flush, drops every rename
//   rs1_id/rs2_id  : operand queries from the decoder
//   get_rob_entryN : tag of rsN sent to the ROB; readyN/valueN come back
//   rsN_ready/rsN_value/rsN_tag : resolved operands (combinational)
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int ROB_BIT = 4,
    parameter int REG_BIT = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_pollute,
    input  logic [REG_BIT-1:0] issue_reg_id,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               rob_commit,
    input  logic [REG_BIT-1:0] commit_rd_reg_id,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [31:0]        commit_value,
    input  logic               clear_up,
    input  logic [REG_BIT-1:0] rs1_id,
    input  logic [REG_BIT-1:0] rs2_id,
    output logic [ROB_BIT-1:0] get_rob_entry1,
    output logic [ROB_BIT-1:0] get_rob_entry2,
    input  logic               ready1,
    input  logic [31:0]        value1,
    input  logic               ready2,
    input  logic [31:0]        value2,
    output logic               rs1_ready,
    output logic [31:0]        rs1_value,
    output logic [ROB_BIT-1:0] rs1_tag,
    output logic               rs2_ready,
    output logic [31:0]        rs2_value,
    output logic [ROB_BIT-1:0] rs2_tag
);

    localparam int NUM_REGS = 1 << REG_BIT;

    logic [31:0]        value_r [NUM_REGS];
    logic [ROB_BIT-1:0] tag_r   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;

    // Register state update: commit writes the value, issue renames, flush drops renames.
    // Entry 0 is never touched after reset, so x0 stays value 0 / not busy / tag 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_r <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                value_r[i] <= 32'h0000_0000;
                tag_r[i]   <= {ROB_BIT{1'b0}};
            end
        end else if (rdy_in) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rob_commit && (commit_rd_reg_id == REG_BIT'(i))) begin
                    value_r[i] <= commit_value;
                end
                // Flush beats issue; issue beats the commit-side busy clear so a
                // same-cycle re-rename keeps the register waiting on the new producer.
                if (clear_up) begin
                    busy_r[i] <= 1'b0;
                end else if (issue_pollute && (issue_reg_id == REG_BIT'(i))) begin
                    busy_r[i] <= 1'b1;
                    tag_r[i]  <= issue_rob_entry;
                end else if (rob_commit && (commit_rd_reg_id == REG_BIT'(i))
                             && (tag_r[i] == commit_rob_entry)) begin
                    busy_r[i] <= 1'b0;
                end
            end
        end
    end

    assign get_rob_entry1 = tag_r[rs1_id];
    assign get_rob_entry2 = tag_r[rs2_id];

    // Operand 1 resolution: x0, committed value, commit bypass, ROB forward, else wait.
    always_comb begin
        rs1_ready = 1'b0;
        rs1_value = 32'h0000_0000;
        rs1_tag   = tag_r[rs1_id];
        if (rs1_id == {REG_BIT{1'b0}}) begin
            rs1_ready = 1'b1;
        end else if (!busy_r[rs1_id]) begin
            rs1_ready = 1'b1;
            rs1_value = value_r[rs1_id];
        end else if (rob_commit && (commit_rd_reg_id == rs1_id)
                     && (commit_rob_entry == tag_r[rs1_id])) begin
            rs1_ready = 1'b1;
            rs1_value = commit_value;
        end else if (ready1) begin
            rs1_ready = 1'b1;
            rs1_value = value1;
        end else begin
            rs1_ready = 1'b0;
            rs1_value = 32'h0000_0000;
        end
    end

    // Operand 2 resolution: same priority as operand 1.
    always_comb begin
        rs2_ready = 1'b0;
        rs2_value = 32'h0000_0000;
        rs2_tag   = tag_r[rs2_id];
        if (rs2_id == {REG_BIT{1'b0}}) begin
            rs2_ready = 1'b1;
        end else if (!busy_r[rs2_id]) begin
            rs2_ready = 1'b1;
            rs2_value = value_r[rs2_id];
        end else if (rob_commit && (commit_rd_reg_id == rs2_id)
                     && (commit_rob_entry == tag_r[rs2_id])) begin
            rs2_ready = 1'b1;
            rs2_value = commit_value;
        end else if (ready2) begin
            rs2_ready = 1'b1;
            rs2_value = value2;
        end else begin
            rs2_ready = 1'b0;
            rs2_value = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file: directed scenarios followed by randomized
// traffic, all compared against a behavioural register/rename model.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int ROB_BIT = 4;
    localparam int REG_BIT = 5;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               issue_pollute;
    logic [REG_BIT-1:0] issue_reg_id;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               rob_commit;
    logic [REG_BIT-1:0] commit_rd_reg_id;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic [31:0]        commit_value;
    logic               clear_up;
    logic [REG_BIT-1:0] rs1_id;
    logic [REG_BIT-1:0] rs2_id;
    logic [ROB_BIT-1:0] get_rob_entry1;
    logic [ROB_BIT-1:0] get_rob_entry2;
    logic               ready1;
    logic [31:0]        value1;
    logic               ready2;
    logic [31:0]        value2;
    logic               rs1_ready;
    logic [31:0]        rs1_value;
    logic [ROB_BIT-1:0] rs1_tag;
    logic               rs2_ready;
    logic [31:0]        rs2_value;
    logic [ROB_BIT-1:0] rs2_tag;

    reg_file #(.ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_pollute(issue_pollute), .issue_reg_id(issue_reg_id),
        .issue_rob_entry(issue_rob_entry), .rob_commit(rob_commit),
        .commit_rd_reg_id(commit_rd_reg_id), .commit_rob_entry(commit_rob_entry),
        .commit_value(commit_value), .clear_up(clear_up),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
        .ready1(ready1), .value1(value1), .ready2(ready2), .value2(value2),
        .rs1_ready(rs1_ready), .rs1_value(rs1_value), .rs1_tag(rs1_tag),
        .rs2_ready(rs2_ready), .rs2_value(rs2_value), .rs2_tag(rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed value, in-flight flag and producer entry per register.
    logic [31:0]        m_val  [32];
    logic               m_busy [32];
    logic [ROB_BIT-1:0] m_tag  [32];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 32'h0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endfunction

    // Operand resolution as the decoder would see it before this cycle's edge.
    task automatic model_query(input int id, input logic rr, input logic [31:0] rv,
                               output logic er, output logic [31:0] ev);
        if (id == 0) begin
            er = 1'b1; ev = 32'h0;
        end else if (!m_busy[id]) begin
            er = 1'b1; ev = m_val[id];
        end else if (rob_commit && commit_rd_reg_id == id && commit_rob_entry == m_tag[id]) begin
            er = 1'b1; ev = commit_value;
        end else if (rr) begin
            er = 1'b1; ev = rv;
        end else begin
            er = 1'b0; ev = 32'h0;
        end
    endtask

    // Architectural effect of one clock edge.
    function automatic void model_edge();
        int cr;
        int ir;
        cr = commit_rd_reg_id;
        ir = issue_reg_id;
        if (!rst_in || !rdy_in) return;
        if (rob_commit && cr != 0) begin
            m_val[cr] = commit_value;
            if (m_tag[cr] == commit_rob_entry) m_busy[cr] = 1'b0;
        end
        if (clear_up) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (issue_pollute && ir != 0) begin
            m_busy[ir] = 1'b1;
            m_tag[ir]  = issue_rob_entry;
        end
    endfunction

    task automatic settle();
        logic        er;
        logic [31:0] ev;
        #1;
        model_query(rs1_id, ready1, value1, er, ev);
        check("rs1_ready", rs1_ready, er);
        check("rs1_value", rs1_value, ev);
        if (!er) check("rs1_tag", rs1_tag, m_tag[rs1_id]);
        check("get_rob_entry1", get_rob_entry1, m_tag[rs1_id]);
        model_query(rs2_id, ready2, value2, er, ev);
        check("rs2_ready", rs2_ready, er);
        check("rs2_value", rs2_value, ev);
        if (!er) check("rs2_tag", rs2_tag, m_tag[rs2_id]);
        check("get_rob_entry2", get_rob_entry2, m_tag[rs2_id]);
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rdy_in = 1'b1; issue_pollute = 1'b0; issue_reg_id = '0; issue_rob_entry = '0;
        rob_commit = 1'b0; commit_rd_reg_id = '0; commit_rob_entry = '0;
        commit_value = 32'h0; clear_up = 1'b0; ready1 = 1'b0; value1 = 32'h0;
        ready2 = 1'b0; value2 = 32'h0;
    endtask

    task automatic do_issue(input int rd, input int entry);
        idle();
        issue_pollute = 1'b1; issue_reg_id = REG_BIT'(rd); issue_rob_entry = ROB_BIT'(entry);
        settle(); tick();
    endtask

    task automatic do_commit(input int rd, input int entry, input logic [31:0] v);
        idle();
        rob_commit = 1'b1; commit_rd_reg_id = REG_BIT'(rd);
        commit_rob_entry = ROB_BIT'(entry); commit_value = v;
        settle(); tick();
    endtask

    initial begin
        idle();
        rs1_id = 5'd5; rs2_id = 5'd0;
        rst_in = 1'b0;
        model_reset();
        @(negedge clk_in);

        // Reset state
        settle();
        check("rst_rs1_ready", rs1_ready, 1'b1);
        check("rst_rs1_value", rs1_value, 32'h0);
        check("rst_rs2_ready", rs2_ready, 1'b1);
        check("rst_rs2_value", rs2_value, 32'h0);
        check("rst_get1", get_rob_entry1, 4'd0);
        tick();
        rst_in = 1'b1;

        // Commit without a prior issue
        do_commit(5, 0, 32'h1234);
        idle(); rs1_id = 5'd5; settle();
        check("x5_ready", rs1_ready, 1'b1);
        check("x5_value", rs1_value, 32'h1234);

        // Rename then ROB forward
        do_issue(3, 7);
        idle(); rs1_id = 5'd3; settle();
        check("x3_wait_ready", rs1_ready, 1'b0);
        check("x3_wait_tag", rs1_tag, 4'd7);
        check("x3_get1", get_rob_entry1, 4'd7);
        ready1 = 1'b1; value1 = 32'hAA; settle();
        check("x3_fwd_ready", rs1_ready, 1'b1);
        check("x3_fwd_value", rs1_value, 32'hAA);
        tick();

        // Older producer commit must not clear a younger rename
        do_issue(3, 2);
        do_issue(3, 5);
        do_commit(3, 2, 32'h11);
        idle(); rs1_id = 5'd3; settle();
        check("x3_still_busy", rs1_ready, 1'b0);
        check("x3_young_tag", rs1_tag, 4'd5);
        do_commit(3, 5, 32'h22);
        idle(); rs1_id = 5'd3; settle();
        check("x3_done_ready", rs1_ready, 1'b1);
        check("x3_done_value", rs1_value, 32'h22);

        // Same-cycle commit and issue to x4, with bypass on the query
        do_issue(4, 1);
        idle();
        rob_commit = 1'b1; commit_rd_reg_id = 5'd4; commit_rob_entry = 4'd1; commit_value = 32'h99;
        issue_pollute = 1'b1; issue_reg_id = 5'd4; issue_rob_entry = 4'd6;
        rs1_id = 5'd4; settle();
        check("x4_bypass_ready", rs1_ready, 1'b1);
        check("x4_bypass_value", rs1_value, 32'h99);
        tick();
        idle(); rs1_id = 5'd4; settle();
        check("x4_busy", rs1_ready, 1'b0);
        check("x4_tag", rs1_tag, 4'd6);
        clear_up = 1'b1; settle(); tick();
        idle(); rs1_id = 5'd4; settle();
        check("x4_value", rs1_value, 32'h99);

        // Flush with a concurrent issue
        do_issue(1, 1); do_issue(2, 2); do_issue(8, 3);
        idle(); clear_up = 1'b1; issue_pollute = 1'b1; issue_reg_id = 5'd9; issue_rob_entry = 4'd4;
        settle(); tick();
        idle(); rs1_id = 5'd1; rs2_id = 5'd9; settle();
        check("flush_x1", rs1_ready, 1'b1);
        check("flush_x9", rs2_ready, 1'b1);
        rs1_id = 5'd2; rs2_id = 5'd8; settle();
        check("flush_x2", rs1_ready, 1'b1);
        check("flush_x8", rs2_ready, 1'b1);

        // x0 is immutable; rdy_in low freezes state
        idle(); issue_pollute = 1'b1; issue_reg_id = 5'd0; issue_rob_entry = 4'd5;
        rob_commit = 1'b1; commit_rd_reg_id = 5'd0; commit_value = 32'hDEAD; commit_rob_entry = 4'd0;
        settle(); tick();
        idle(); rs1_id = 5'd0; settle();
        check("x0_ready", rs1_ready, 1'b1);
        check("x0_value", rs1_value, 32'h0);
        idle(); rdy_in = 1'b0; issue_pollute = 1'b1; issue_reg_id = 5'd6; issue_rob_entry = 4'd3;
        settle(); tick();
        idle(); rs1_id = 5'd6; settle();
        check("x6_frozen", rs1_ready, 1'b1);

        // Asynchronous reset mid-operation drops renames at once
        do_issue(7, 9);
        do_commit(10, 0, 32'h5555);
        idle(); rs1_id = 5'd7; rs2_id = 5'd10;
        rst_in = 1'b0; model_reset(); settle();
        check("arst_x7_ready", rs1_ready, 1'b1);
        check("arst_x10_value", rs2_value, 32'h0);
        tick();
        rst_in = 1'b1;

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy_in           = ($urandom_range(0, 9) != 0);
            issue_pollute    = $urandom_range(0, 1);
            issue_reg_id     = REG_BIT'($urandom_range(0, 7));
            issue_rob_entry  = ROB_BIT'($urandom);
            rob_commit       = $urandom_range(0, 1);
            commit_rd_reg_id = REG_BIT'($urandom_range(0, 7));
            commit_rob_entry = ($urandom_range(0, 3) != 0) ? m_tag[commit_rd_reg_id]
                                                           : ROB_BIT'($urandom);
            commit_value     = $urandom;
            clear_up         = ($urandom_range(0, 29) == 0);
            rs1_id           = REG_BIT'($urandom_range(0, 8));
            rs2_id           = REG_BIT'($urandom_range(0, 8));
            ready1           = ($urandom_range(0, 3) == 0);
            value1           = $urandom;
            ready2           = ($urandom_range(0, 3) == 0);
            value2           = $urandom;
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags, sitting directly downstream of the ROB's commit port and beside its issue/operand-query ports.
- Holds the 32 committed integer register values.
- Tracks which registers have an in-flight producer and the ROB entry of that producer.
- Resolves source operands for the decoder. The result is either a ready value (committed, or forwarded from the ROB) or a ROB tag to wait on.

Parameters:
- ROB_BIT, 4, width of a ROB entry index; must equal the ROB's index width.
- REG_BIT, 5, width of a register index (32 registers).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; state frozen when low
- issue_pollute  input  1  instruction being issued this cycle writes a register
- issue_reg_id  input  REG_BIT  destination register of the issuing instruction
- issue_rob_entry  input  ROB_BIT  ROB entry allocated to the issuing instruction
- rob_commit  input  1  head instruction retires with a register result
- commit_rd_reg_id  input  REG_BIT  retiring destination register
- commit_rob_entry  input  ROB_BIT  ROB entry retiring
- commit_value  input  32  retiring result
- clear_up  input  1  misprediction flush from the ROB
- rs1_id  input  REG_BIT  source register 1 queried by the decoder
- rs2_id  input  REG_BIT  source register 2 queried by the decoder
- get_rob_entry1  output  ROB_BIT  tag[rs1_id], sent to the ROB for a ready/value lookup
- get_rob_entry2  output  ROB_BIT  tag[rs2_id]
- ready1  input  1  ROB: entry get_rob_entry1 has its value
- value1  input  32  ROB: value of get_rob_entry1
- ready2  input  1  ROB: entry get_rob_entry2 has its value
- value2  input  32  ROB: value of get_rob_entry2
- rs1_ready  output  1  rs1 operand value is valid
- rs1_value  output  32  rs1 operand value; 0 when not ready
- rs1_tag  output  ROB_BIT  ROB entry to wait on when not ready
- rs2_ready  output  1  same as rs1_ready, for rs2
- rs2_value  output  32  same as rs1_value, for rs2
- rs2_tag  output  ROB_BIT  same as rs1_tag, for rs2

Behaviour:
- State per register i: value[i] (32), busy[i] (1), tag[i] (ROB_BIT).
- Reset (rst_in low, asynchronous): all value, busy and tag cleared to 0; the state is held cleared while rst_in is low.
  - Reset mid-operation discards all in-flight tags immediately.
  - Every output is then combinational from cleared state: rs*_ready=1, rs*_value=0, tag outputs 0.
- rdy_in low: no state change; combinational outputs stay live.
- Register x0:
  - value[0] is never written; busy[0] is never set.
  - Queries of x0 always return ready=1, value=0.
  - Issue or commit targeting x0 is ignored.
- Commit (posedge, rdy_in, rob_commit, rd != 0):
  - value[rd] <= commit_value unconditionally.
  - busy[rd] is cleared only if tag[rd]==commit_rob_entry (no younger producer).
- Issue (posedge, rdy_in, issue_pollute, rd != 0, !clear_up): busy[rd] <= 1, tag[rd] <= issue_rob_entry.
- Same-cycle issue and commit to the same rd: issue wins. busy stays 1, tag takes the new entry, value takes commit_value.
- clear_up (posedge, rdy_in):
  - All busy cleared; issue that cycle is ignored.
  - A commit in the same cycle still writes value (not expected in practice; the ROB flushes on a branch head, which does not commit a register).
- Operand query: purely combinational, zero latency. Priority for rsN, highest first:
  1. id==0 → ready, value 0.
  2. !busy[id] → ready, value[id].
  3. busy and rob_commit && commit_rd_reg_id==id && commit_rob_entry==tag[id] → ready, commit_value (bypass).
  4. busy and readyN → ready, valueN (ROB forward).
  5. Otherwise → not ready, value 0, rsN_tag=tag[id].
- get_rob_entryN = tag[rsN_id] always, regardless of busy.
- Queries see pre-issue state: an instruction's own rd rename never affects its own operands (e.g. add x1,x1,x1 reads the old producer of x1).
- Tag wrap-around needs no special handling: the ROB never holds two live entries with the same index.

Test Plan:
- Reset → query rs1=5, rs2=0 → both ready, value 0; release reset, commit x5=0x1234 (no prior issue) → next cycle rs1=5 returns ready, 0x1234.
- Issue x3 with tag 7; next cycle query x3 with ROB ready1=0 → rs1_ready=0, rs1_tag=7, get_rob_entry1=7; drive ready1=1, value1=0xAA → rs1_ready=1, rs1_value=0xAA.
- Issue x3 tag 2, then issue x3 tag 5, then commit x3 entry 2 value 0x11 → value[3]=0x11 but x3 still busy with tag 5; commit entry 5 value 0x22 → x3 ready, value 0x22.
- Same cycle: commit x4 entry 1 value 0x99 (tag matches) and issue x4 tag 6 → afterwards x4 busy, tag 6, value 0x99. Query x4 during that cycle → ready via bypass, value 0x99.
- Issue x1, x2, x8 (tags 1, 2, 3), then clear_up with a concurrent issue of x9 → all four registers are non-busy; x9 is not renamed; values unchanged.
- Issue/commit targeting x0, and rdy_in low while issuing x6 → x0 is never busy and reads 0; x6 is unchanged while rdy_in is low.
